board_ctrl: RTL and testbench

Game-state controller that owns the 8x8 `board_data` vector feeding the VGA chess renderer. It turns one-cycle button pulses into three kinds of change: cursor motion, piece selection, and piece moves or captures. All changes go into a shadow board. The shadow is copied to the displayed board only during vertical blanking, so the renderer never shows a half-updated frame.

---
 rtl/board_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_board_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : board_ctrl
// Brief   : Chess game-state controller; edits a shadow board from button
//           pulses and commits it to board_data during vertical blanking.
//           Option macro: BOARD_CTRL_TURN_CHECK_EN (turn-checked selection).
// Revision: 1.0 - initial release
// ============================================================================
module board_ctrl #(
   parameter int FRAME_HOLD = 0
) (
   input  logic         pclk,
   input  logic         rst,
   input  logic         ven,
   input  logic         btn_up,
   input  logic         btn_down,
   input  logic         btn_left,
   input  logic         btn_right,
   input  logic         btn_sel,
   input  logic         btn_cancel,
   output logic [767:0] board_data,
   output logic [2:0]   cursor_row,
   output logic [2:0]   cursor_col,
   output logic         sel_valid,
   output logic         turn,
   output logic         dirty,
   output logic [15:0]  move_cnt
);

   localparam logic [0:0]  c_IDLE       = 1'b0;
   localparam logic [0:0]  c_SEL        = 1'b1;
   localparam logic [3:0]  c_HOLD       = 4'(FRAME_HOLD);
   localparam logic [31:0] c_BLACK_BACK = 32'hDCBA9BCD;
   localparam logic [31:0] c_WHITE_BACK = 32'h54321345;

   function automatic logic [767:0] f_init_board();
      logic [767:0] b;
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[12*c +: 12]      = {c_BLACK_BACK[4*(7-c) +: 4], 8'h80};
         b[12*(8+c) +: 12]  = 12'hE80;
         b[12*(48+c) +: 12] = 12'h680;
         b[12*(56+c) +: 12] = {c_WHITE_BACK[4*(7-c) +: 4], 8'h80};
      end
      b[12*60+3] = 1'b1;
      return b;
   endfunction

   // Cell k starts at bit 12k = 8k + 4k.
   function automatic logic [9:0] f_lsb(input logic [5:0] k);
      return {1'b0, k, 3'b000} + {2'b00, k, 2'b00};
   endfunction

   localparam logic [767:0] c_INIT_BOARD = f_init_board();

   logic [767:0] r_shadow;
   logic [767:0] r_board;
   logic [2:0]   r_row;
   logic [2:0]   r_col;
   logic [5:0]   r_src;
   logic [0:0]   r_state;
   logic         r_turn;
   logic         r_dirty;
   logic [15:0]  r_move_cnt;
   logic [3:0]   r_blank_cnt;

   logic [767:0] w_shadow_n;
   logic [2:0]   w_row_n;
   logic [2:0]   w_col_n;
   logic [5:0]   w_src_n;
   logic [0:0]   w_state_n;
   logic         w_turn_n;
   logic [15:0]  w_cnt_n;
   logic         w_change;
   logic         w_commit;
   logic [5:0]   w_cur;
   logic [9:0]   w_cur_lsb;
   logic [9:0]   w_src_lsb;
   logic [9:0]   w_new_lsb;
   logic         w_cur_selectable;

   assign w_cur     = {r_row, r_col};
   assign w_cur_lsb = f_lsb(w_cur);
   assign w_src_lsb = f_lsb(r_src);

`ifdef BOARD_CTRL_TURN_CHECK_EN
   assign w_cur_selectable = r_shadow[w_cur_lsb + 10'd7] &&
                             (r_shadow[w_cur_lsb + 10'd11] == r_turn);
`else
   assign w_cur_selectable = r_shadow[w_cur_lsb + 10'd7];
`endif

   // ven must have been low for FRAME_HOLD prior cycles plus this one.
   assign w_commit = r_dirty && !ven && (r_blank_cnt >= c_HOLD);

   always_comb begin
      w_shadow_n = r_shadow;
      w_row_n    = r_row;
      w_col_n    = r_col;
      w_src_n    = r_src;
      w_state_n  = r_state;
      w_turn_n   = r_turn;
      w_cnt_n    = r_move_cnt;
      w_change   = 1'b0;
      w_new_lsb  = w_cur_lsb;
      if (btn_sel) begin
         if (r_state == c_IDLE) begin
            if (w_cur_selectable) begin
               w_shadow_n[w_cur_lsb + 10'd2] = 1'b1;
               w_src_n   = w_cur;
               w_state_n = c_SEL;
               w_change  = 1'b1;
            end
         end else if (w_cur == r_src) begin
            w_shadow_n[w_src_lsb + 10'd2] = 1'b0;
            w_state_n = c_IDLE;
            w_change  = 1'b1;
         end else if (w_cur_selectable) begin
            w_shadow_n[w_src_lsb + 10'd2] = 1'b0;
            w_shadow_n[w_cur_lsb + 10'd2] = 1'b1;
            w_src_n  = w_cur;
            w_change = 1'b1;
         end else begin
            // Move or capture: piece type and occupancy travel to the cursor.
            w_shadow_n[w_cur_lsb + 10'd7 +: 5] = r_shadow[w_src_lsb + 10'd7 +: 5];
            w_shadow_n[w_src_lsb + 10'd7 +: 5] = 5'd0;
            w_shadow_n[w_src_lsb + 10'd2]      = 1'b0;
            w_turn_n  = ~r_turn;
            w_cnt_n   = r_move_cnt + 16'd1;
            w_state_n = c_IDLE;
            w_change  = 1'b1;
         end
      end else if (btn_cancel) begin
         if (r_state == c_SEL) begin
            w_shadow_n[w_src_lsb + 10'd2] = 1'b0;
            w_state_n = c_IDLE;
            w_change  = 1'b1;
         end
      end else if (btn_up || btn_down || btn_left || btn_right) begin
         if (btn_up)        w_row_n = r_row - 3'd1;
         else if (btn_down) w_row_n = r_row + 3'd1;
         else if (btn_left) w_col_n = r_col - 3'd1;
         else               w_col_n = r_col + 3'd1;
         w_new_lsb = f_lsb({w_row_n, w_col_n});
         w_shadow_n[w_cur_lsb + 10'd3] = 1'b0;
         w_shadow_n[w_new_lsb + 10'd3] = 1'b1;
         w_change = 1'b1;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_shadow    <= c_INIT_BOARD;
         r_board     <= c_INIT_BOARD;
         r_row       <= 3'd7;
         r_col       <= 3'd4;
         r_src       <= 6'd0;
         r_state     <= c_IDLE;
         r_turn      <= 1'b0;
         r_dirty     <= 1'b0;
         r_move_cnt  <= 16'd0;
         r_blank_cnt <= 4'd0;
      end else begin
         r_shadow   <= w_shadow_n;
         r_row      <= w_row_n;
         r_col      <= w_col_n;
         r_src      <= w_src_n;
         r_state    <= w_state_n;
         r_turn     <= w_turn_n;
         r_move_cnt <= w_cnt_n;
         if (w_commit) begin
            r_board <= r_shadow;
         end
         r_dirty <= w_change || (r_dirty && !w_commit);
         if (ven) begin
            r_blank_cnt <= 4'd0;
         end else if (r_blank_cnt != 4'hF) begin
            r_blank_cnt <= r_blank_cnt + 4'd1;
         end
      end
   end

   assign board_data = r_board;
   assign cursor_row = r_row;
   assign cursor_col = r_col;
   assign sel_valid  = (r_state == c_SEL);
   assign turn       = r_turn;
   assign dirty      = r_dirty;
   assign move_cnt   = r_move_cnt;

endmodule
`default_nettype wire

// File: tb/tb_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_board_ctrl
// Brief   : Bench for board_ctrl against a cell-array game model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_board_ctrl;

   localparam int FRAME_HOLD = 0;

   logic         pclk = 1'b0;
   logic         rst = 1'b1;
   logic         ven = 1'b1;
   logic         btn_up = 1'b0;
   logic         btn_down = 1'b0;
   logic         btn_left = 1'b0;
   logic         btn_right = 1'b0;
   logic         btn_sel = 1'b0;
   logic         btn_cancel = 1'b0;
   logic [767:0] board_data;
   logic [2:0]   cursor_row;
   logic [2:0]   cursor_col;
   logic         sel_valid;
   logic         turn;
   logic         dirty;
   logic [15:0]  move_cnt;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   board_ctrl #(.FRAME_HOLD(FRAME_HOLD)) dut (
      .pclk       (pclk),
      .rst        (rst),
      .ven        (ven),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_sel    (btn_sel),
      .btn_cancel (btn_cancel),
      .board_data (board_data),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .sel_valid  (sel_valid),
      .turn       (turn),
      .dirty      (dirty),
      .move_cnt   (move_cnt)
   );

   always #5 pclk = ~pclk;

   // Game model: piece code per square (0 empty, 1..6 white, 9..14 black).
   int m_piece [64];
   int m_disp_piece [64];
   int m_row, m_col, m_src, m_cnt, m_run;
   int m_disp_cur, m_disp_src;
   bit m_sel, m_turn, m_dirty;

   function automatic logic [767:0] render(input int p [64], input int cur, input int src);
      logic [767:0] b;
      logic [11:0]  c;
      int           code;
      b = '0;
      for (int k = 0; k < 64; k++) begin
         code    = p[k];
         c       = '0;
         c[11:8] = code[3:0];
         c[7]    = (code != 0);
         c[3]    = (k == cur);
         c[2]    = (k == src);
         b[12*k +: 12] = c;
      end
      return b;
   endfunction

   function automatic bit selectable(input int code);
`ifdef BOARD_CTRL_TURN_CHECK_EN
      return (code != 0) && (((code >> 3) & 1) == int'(m_turn));
`else
      return (code != 0);
`endif
   endfunction

   task automatic m_reset();
      int back [8];
      back = '{5, 4, 3, 2, 1, 3, 4, 5};
      for (int k = 0; k < 64; k++) m_piece[k] = 0;
      for (int c = 0; c < 8; c++) begin
         m_piece[c]      = back[c] + 8;
         m_piece[8 + c]  = 14;
         m_piece[48 + c] = 6;
         m_piece[56 + c] = back[c];
      end
      m_row = 7; m_col = 4; m_sel = 0; m_src = 0;
      m_turn = 0; m_dirty = 0; m_cnt = 0; m_run = 0;
      m_disp_piece = m_piece;
      m_disp_cur = 60;
      m_disp_src = -1;
   endtask

   // Advance the model by one pclk edge using the inputs held over that edge.
   task automatic m_step();
      bit chg;
      bit commit;
      int cur;
      if (rst) begin
         m_reset();
         return;
      end
      chg    = 0;
      m_run  = ven ? 0 : m_run + 1;
      commit = m_dirty && !ven && (m_run >= FRAME_HOLD + 1);
      if (commit) begin
         m_disp_piece = m_piece;
         m_disp_cur   = m_row * 8 + m_col;
         m_disp_src   = m_sel ? m_src : -1;
      end
      cur = m_row * 8 + m_col;
      if (btn_sel) begin
         if (!m_sel) begin
            if (selectable(m_piece[cur])) begin
               m_sel = 1; m_src = cur; chg = 1;
            end
         end else if (cur == m_src) begin
            m_sel = 0; chg = 1;
         end else if (selectable(m_piece[cur])) begin
            m_src = cur; chg = 1;
         end else begin
            m_piece[cur]   = m_piece[m_src];
            m_piece[m_src] = 0;
            m_sel  = 0;
            m_turn = ~m_turn;
            m_cnt  = (m_cnt + 1) % 65536;
            chg    = 1;
         end
      end else if (btn_cancel) begin
         if (m_sel) begin
            m_sel = 0; chg = 1;
         end
      end else if (btn_up) begin
         m_row = (m_row + 7) % 8; chg = 1;
      end else if (btn_down) begin
         m_row = (m_row + 1) % 8; chg = 1;
      end else if (btn_left) begin
         m_col = (m_col + 7) % 8; chg = 1;
      end else if (btn_right) begin
         m_col = (m_col + 1) % 8; chg = 1;
      end
      m_dirty = chg || (m_dirty && !commit);
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_board(input string name, input logic [767:0] act, input logic [767:0] exp);
      checks++;
      if (act != exp) begin
         failures++;
         for (int k = 0; k < 64; k++) begin
            if (act[12*k +: 12] != exp[12*k +: 12]) begin
               $display("FAIL %s: cell %0d got 0x%03h expected 0x%03h at %0t",
                        name, k, act[12*k +: 12], exp[12*k +: 12], $time);
               break;
            end
         end
      end
   endtask

   task automatic chk_cell(input string name, input int k, input logic [11:0] exp);
      chk(name, longint'(board_data[12*k +: 12]), longint'(exp));
   endtask

   always @(negedge pclk) begin
      if (cmp_en) begin
         chk_board("board_data", board_data, render(m_disp_piece, m_disp_cur, m_disp_src));
         chk("cursor_row", longint'(cursor_row), longint'(m_row));
         chk("cursor_col", longint'(cursor_col), longint'(m_col));
         chk("sel_valid", longint'(sel_valid), longint'(m_sel));
         chk("turn", longint'(turn), longint'(m_turn));
         chk("dirty", longint'(dirty), longint'(m_dirty));
         chk("move_cnt", longint'(move_cnt), longint'(m_cnt));
      end
   end

   task automatic cyc(input bit s, input bit c, input bit u, input bit d,
                      input bit l, input bit r, input bit v);
      @(negedge pclk);
      btn_sel = s; btn_cancel = c; btn_up = u; btn_down = d;
      btn_left = l; btn_right = r; ven = v;
      @(posedge pclk);
      #1;
      m_step();
   endtask

   task automatic idle(input bit v);
      cyc(0, 0, 0, 0, 0, 0, v);
   endtask

   task automatic rst_on();
      @(negedge pclk);
      #2;
      rst = 1'b1;
      btn_sel = 0; btn_cancel = 0; btn_up = 0; btn_down = 0;
      btn_left = 0; btn_right = 0;
      m_reset();
      #1;
   endtask

   task automatic rst_off();
      @(posedge pclk);
      #1;
      m_step();
      @(negedge pclk);
      #2;
      rst = 1'b0;
      @(posedge pclk);
      #1;
      m_step();
   endtask

   initial begin
      int n;
      int seg;
      bit v;

      rst_on();
      cmp_en = 1'b1;
      rst_off();

      // Reset position pinned to literal cell codes.
      chk_cell("reset_cell60", 60, 12'h188);
      chk_cell("reset_cell0", 0, 12'hD80);
      chk_cell("reset_cell3", 3, 12'hA80);
      chk_cell("reset_cell63", 63, 12'h580);
      chk_cell("reset_cell36", 36, 12'h000);
      chk("reset_dirty", longint'(dirty), 0);

      // Three ups in blanking, then one commit.
      repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
      chk("up3_row", longint'(cursor_row), 4);
      chk("up3_dirty", longint'(dirty), 1);
      idle(0);
      n = 0;
      for (int k = 0; k < 64; k++) n += int'(board_data[12*k + 3]);
      chk("up3_cursor_bits", n, 1);
      chk_cell("up3_cell36", 36, 12'h008);
      chk_cell("up3_cell60", 60, 12'h180);
      chk("up3_dirty_clear", longint'(dirty), 0);

      // Pawn move while video active, committed once blanking starts.
      rst_on(); rst_off();
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("pawn_sel_valid", longint'(sel_valid), 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      idle(1);
      chk_cell("pawn_active_cell52", 52, 12'h680);
      chk_cell("pawn_active_cell36", 36, 12'h000);
      chk("pawn_turn", longint'(turn), 1);
      chk("pawn_move_cnt", longint'(move_cnt), 1);
      idle(0);
      chk_cell("pawn_commit_cell36", 36, 12'h688);
      chk_cell("pawn_commit_cell52", 52, 12'h000);

      // sel beats left in the same cycle.
      rst_on(); rst_off();
      cyc(1, 0, 0, 0, 1, 0, 1);
      chk("sel_left_sel_valid", longint'(sel_valid), 1);
      chk("sel_left_col", longint'(cursor_col), 4);
      cyc(0, 1, 0, 0, 0, 0, 1);
      chk("cancel_sel_valid", longint'(sel_valid), 0);

      // Wrap-around from (0,0).
      repeat (7) cyc(0, 0, 1, 0, 0, 0, 1);
      repeat (4) cyc(0, 0, 0, 0, 1, 0, 1);
      chk("corner_row", longint'(cursor_row), 0);
      chk("corner_col", longint'(cursor_col), 0);
      cyc(0, 0, 0, 0, 1, 0, 1);
      chk("wrap_left_col", longint'(cursor_col), 7);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("wrap_up_row", longint'(cursor_row), 7);

      rst_on(); rst_off();
`ifdef BOARD_CTRL_TURN_CHECK_EN
      repeat (6) cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("opp_sel_ignored", longint'(sel_valid), 0);
      repeat (5) cyc(0, 0, 0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      repeat (5) cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      idle(0);
      chk_cell("capture_cell12", 12, 12'h688);
      chk("capture_white", longint'(board_data[12*12 + 11]), 0);
      chk("capture_turn", longint'(turn), 1);
`else
      cyc(1, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("reselect_sel_valid", longint'(sel_valid), 1);
      chk("reselect_move_cnt", longint'(move_cnt), 0);
      idle(0);
      chk_cell("reselect_cell52", 52, 12'h68C);
      chk_cell("reselect_cell60", 60, 12'h180);
`endif

      // Reset while a selection and a commit are pending.
      rst_on(); rst_off();
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("pre_rst_dirty", longint'(dirty), 1);
      chk("pre_rst_sel", longint'(sel_valid), 1);
      rst_on();
      chk("rst_dirty", longint'(dirty), 0);
      chk("rst_sel_valid", longint'(sel_valid), 0);
      chk_cell("rst_cell60", 60, 12'h188);
      rst_off();

      // Randomised play with random blanking segments.
      seg = 0;
      v = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         bit s, c, u, d, l, r;
         if (seg == 0) begin
            v   = 1'($urandom_range(0, 1));
            seg = $urandom_range(1, 30);
         end
         seg--;
         if ($urandom_range(0, 599) == 0) begin
            rst_on();
            rst_off();
         end else begin
            s = 0; c = 0; u = 0; d = 0; l = 0; r = 0;
            if ($urandom_range(0, 2) == 0) begin
               s = ($urandom_range(0, 2) == 0);
               c = ($urandom_range(0, 5) == 0);
               u = ($urandom_range(0, 3) == 0);
               d = ($urandom_range(0, 3) == 0);
               l = ($urandom_range(0, 3) == 0);
               r = ($urandom_range(0, 3) == 0);
            end
            cyc(s, c, u, d, l, r, v);
         end
      end
      idle(0);
      idle(0);
      @(negedge pclk);
      #1;
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
